alu_ctrl_pipe: RTL and testbench

Parametrised, registered successor to the combinational ALU control decoder in the MIPS datapath. Decodes `ALUOp`/`Func` into an ALU select code, places it in a one-entry output register with a valid/ready handshake at the ID/EX boundary, and owns the sequencer for iterative multiply/divide. It stalls HI/LO reads and a second mult/div until the unit is free, and flags undefined encodings.

---
 rtl/alu_ctrl_pkg.sv | 54 +++++
 rtl/alu_ctrl_pipe_if.sv | 29 ++
 rtl/md_sequencer.sv | 67 ++++++
 rtl/alu_ctrl_pipe.sv | 98 +++++++++
 tb/tb_alu_ctrl_pipe.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the registered ALU control decoder and
// its multiply/divide sequencer.
package alu_ctrl_pkg;

    localparam logic [3:0] SEL_AND  = 4'd0;
    localparam logic [3:0] SEL_OR   = 4'd1;
    localparam logic [3:0] SEL_ADD  = 4'd2;
    localparam logic [3:0] SEL_XOR  = 4'd3;
    localparam logic [3:0] SEL_SLL  = 4'd4;
    localparam logic [3:0] SEL_SRL  = 4'd5;
    localparam logic [3:0] SEL_SUB  = 4'd6;
    localparam logic [3:0] SEL_SLT  = 4'd7;
    localparam logic [3:0] SEL_SLTU = 4'd8;
    localparam logic [3:0] SEL_SRA  = 4'd9;
    localparam logic [3:0] SEL_NOR  = 4'd12;
    localparam logic [3:0] SEL_MFHI = 4'd13;
    localparam logic [3:0] SEL_MFLO = 4'd14;
    localparam logic [3:0] SEL_NOP  = 4'd15;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ANDI  = 3'b001;
    localparam logic [2:0] ALUOP_MEM   = 3'b010;
    localparam logic [2:0] ALUOP_ORI   = 3'b011;
    localparam logic [2:0] ALUOP_SLTI  = 3'b100;
    localparam logic [2:0] ALUOP_SLTIU = 3'b101;
    localparam logic [2:0] ALUOP_BEQ   = 3'b110;
    localparam logic [2:0] ALUOP_UNDEF = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    // Encoding matches Func[1:0] of the mult/div group.
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} md_state_e;

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// ID/EX handshake and mult/div status bundle for alu_ctrl_pipe.
interface alu_ctrl_pipe_if #(
    parameter int SEL_W   = 4,
    parameter int ALUOP_W = 3
);
    logic               in_valid;
    logic [ALUOP_W-1:0] ALUOp;
    logic [5:0]         Func;
    logic               in_ready;
    logic               flush;
    logic               out_ready;
    logic               out_valid;
    logic [SEL_W-1:0]   Sel;
    logic               illegal;
    logic               md_start;
    logic [1:0]         md_op;
    logic               md_busy;
    logic               md_done;

    modport master (
        output in_valid, ALUOp, Func, flush, out_ready,
        input  in_ready, out_valid, Sel, illegal, md_start, md_op, md_busy, md_done
    );

    modport slave (
        input  in_valid, ALUOp, Func, flush, out_ready,
        output in_ready, out_valid, Sel, illegal, md_start, md_op, md_busy, md_done
    );
endinterface

// File: rtl/md_sequencer.sv
// Iterative multiply/divide sequencer: launches on request, runs MD_CYCLES
// cycles, then pulses md_done for the HI/LO write.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | unit free, waiting for a launch
// ST_RUN  | operation in flight, counter counting down to 0
// ST_DONE | one-cycle HI/LO write slot; a new launch may start here
module md_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       launch,
    input  md_op_e     launch_op,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic       md_done
);
    md_state_e  state_q;
    md_state_e  state_d;
    logic [7:0] cnt_q;
    md_op_e     op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == 8'd0) state_d = ST_DONE;
            ST_DONE: state_d = launch ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        md_busy = (state_q == ST_RUN);
        md_done = (state_q == ST_DONE);
    end

    // Hazard logic upstream guarantees no launch arrives while in ST_RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 8'd0;
            md_start <= 1'b0;
            op_q     <= MD_MULT;
        end else begin
            md_start <= launch;
            if (launch) begin
                cnt_q <= 8'(MD_CYCLES - 1);
                op_q  <= launch_op;
            end else if (state_q == ST_RUN && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign md_op = op_q;

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder at the ID/EX boundary with valid/ready
// handshake, HI/LO hazard stall and mult/div launch.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int SEL_W     = 4,
    parameter int ALUOP_W   = 3,
    parameter int MD_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_pipe_if.slave bus
);
    logic [SEL_W-1:0] dec_sel;
    logic             dec_illegal;
    logic             dec_md;
    logic             dec_hilo;
    logic             hazard;
    logic             accept;
    logic             launch;

    always_comb begin
        dec_sel     = SEL_W'(SEL_NOP);
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        dec_hilo    = 1'b0;
        case (bus.ALUOp)
            ALUOP_W'(ALUOP_RTYPE): begin
                case (bus.Func)
                    FN_ADD, FN_ADDU: dec_sel = SEL_W'(SEL_ADD);
                    FN_SUB, FN_SUBU: dec_sel = SEL_W'(SEL_SUB);
                    FN_AND:          dec_sel = SEL_W'(SEL_AND);
                    FN_OR:           dec_sel = SEL_W'(SEL_OR);
                    FN_XOR:          dec_sel = SEL_W'(SEL_XOR);
                    FN_NOR:          dec_sel = SEL_W'(SEL_NOR);
                    FN_SLT:          dec_sel = SEL_W'(SEL_SLT);
                    FN_SLTU:         dec_sel = SEL_W'(SEL_SLTU);
                    FN_SLL:          dec_sel = SEL_W'(SEL_SLL);
                    FN_SRL:          dec_sel = SEL_W'(SEL_SRL);
                    FN_SRA:          dec_sel = SEL_W'(SEL_SRA);
                    FN_MFHI: begin
                        dec_sel  = SEL_W'(SEL_MFHI);
                        dec_hilo = 1'b1;
                    end
                    FN_MFLO: begin
                        dec_sel  = SEL_W'(SEL_MFLO);
                        dec_hilo = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: dec_md = 1'b1;
                    default:         dec_illegal = 1'b1;
                endcase
            end
            ALUOP_W'(ALUOP_MEM):   dec_sel = SEL_W'(SEL_ADD);
            ALUOP_W'(ALUOP_BEQ):   dec_sel = SEL_W'(SEL_SUB);
            ALUOP_W'(ALUOP_ANDI):  dec_sel = SEL_W'(SEL_AND);
            ALUOP_W'(ALUOP_ORI):   dec_sel = SEL_W'(SEL_OR);
            ALUOP_W'(ALUOP_SLTI):  dec_sel = SEL_W'(SEL_SLT);
            ALUOP_W'(ALUOP_SLTIU): dec_sel = SEL_W'(SEL_SLTU);
            ALUOP_W'(ALUOP_UNDEF): dec_illegal = 1'b1;
            default:               dec_illegal = 1'b1;
        endcase
    end

    // HI/LO readers and a second mult/div wait out RUN; DONE is the write slot
    // so reads there see the fresh result.
    assign hazard       = bus.in_valid && bus.md_busy && (dec_hilo || dec_md);
    assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;
    assign launch       = accept && dec_md;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.Sel       <= SEL_W'(SEL_NOP);
            bus.illegal   <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.Sel       <= dec_sel;
            bus.illegal   <= dec_illegal;
        end else if (bus.flush || bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    md_sequencer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (launch),
        .launch_op (md_op_e'(bus.Func[1:0])),
        .md_start  (bus.md_start),
        .md_op     (bus.md_op),
        .md_busy   (bus.md_busy),
        .md_done   (bus.md_done)
    );

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios plus randomized
// traffic against a cycle-indexed behavioural model.
module tb_alu_ctrl_pipe;
    localparam int M = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_pipe_if #(.SEL_W(4), .ALUOP_W(3)) bus ();

    alu_ctrl_pipe #(
        .SEL_W     (4),
        .ALUOP_W   (3),
        .MD_CYCLES (M)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Decode tables: -1 marks an undefined encoding.
    int rtab[64];
    int itab[8];

    // Model state: output register contents and the cycle of the last
    // accepted mult/div; md_* follow from plain arithmetic on that cycle.
    int cyc;
    bit m_ov;
    int m_sel;
    bit m_ill;
    int m_op;
    int md_t;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_dec(int a, int f, output int sel, output bit ill);
        int v;
        v   = (a == 0) ? rtab[f] : itab[a];
        ill = (v < 0);
        sel = ill ? 15 : v;
    endfunction

    task automatic model_reset();
        m_ov  = 1'b0;
        m_sel = 15;
        m_ill = 1'b0;
        m_op  = 0;
        md_t  = -100000;
    endtask

    task automatic drive(bit iv, int a, int f, bit ordy, bit fl);
        bus.in_valid  = iv;
        bus.ALUOp     = 3'(a);
        bus.Func      = 6'(f);
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // Called at a falling edge with inputs already applied: compares the
    // whole output set against the model, then advances one clock.
    task automatic step(output bit acc);
        int a, f, e_sel;
        bit e_ill, e_busy, e_start, e_done, is_md, is_hilo, hz, e_rdy, fl, ordy;
        #1;
        a       = int'(bus.ALUOp);
        f       = int'(bus.Func);
        fl      = bus.flush;
        ordy    = bus.out_ready;
        e_start = (cyc == md_t + 1);
        e_busy  = (cyc >= md_t + 1) && (cyc <= md_t + M);
        e_done  = (cyc == md_t + M + 1);
        is_md   = (a == 0) && (f >= 24) && (f <= 27);
        is_hilo = (a == 0) && (f == 16 || f == 18);
        hz      = bus.in_valid && e_busy && (is_md || is_hilo);
        e_rdy   = !fl && (!m_ov || ordy) && !hz;
        chk("out_valid", int'(bus.out_valid), int'(m_ov));
        chk("sel",       int'(bus.Sel),       m_sel);
        chk("illegal",   int'(bus.illegal),   int'(m_ill));
        chk("md_start",  int'(bus.md_start),  int'(e_start));
        chk("md_busy",   int'(bus.md_busy),   int'(e_busy));
        chk("md_done",   int'(bus.md_done),   int'(e_done));
        chk("md_op",     int'(bus.md_op),     m_op);
        chk("in_ready",  int'(bus.in_ready),  int'(e_rdy));
        acc = bus.in_valid && e_rdy;
        model_dec(a, f, e_sel, e_ill);
        @(posedge clk);
        if (acc) begin
            m_ov  = 1'b1;
            m_sel = e_sel;
            m_ill = e_ill;
            if (is_md) begin
                md_t = cyc;
                m_op = f - 24;
            end
        end else if (fl || ordy) begin
            m_ov = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int t0;
        bit seen;
        int picks[6];
        picks = '{16, 18, 24, 25, 26, 27};

        for (int i = 0; i < 64; i++) rtab[i] = -1;
        rtab[32] = 2;  rtab[33] = 2;  rtab[34] = 6;  rtab[35] = 6;
        rtab[36] = 0;  rtab[37] = 1;  rtab[38] = 3;  rtab[39] = 12;
        rtab[42] = 7;  rtab[43] = 8;  rtab[0]  = 4;  rtab[2]  = 5;
        rtab[3]  = 9;  rtab[16] = 13; rtab[18] = 14;
        for (int i = 24; i <= 27; i++) rtab[i] = 15;
        itab = '{-1, 0, 2, 1, 7, 8, 6, -1};

        cyc = 0;
        model_reset();
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_sel",       int'(bus.Sel),       15);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        chk("rst_md_busy",   int'(bus.md_busy),   0);

        // Reset then ADD
        drive(1, 0, 32, 1, 0);
        step(acc);
        drive(0, 0, 0, 1, 0);
        chk("add_out_valid", int'(bus.out_valid), 1);
        chk("add_sel",       int'(bus.Sel),       2);
        chk("add_md_start",  int'(bus.md_start),  0);
        step(acc);

        // Full decode sweep, each instruction held until accepted
        for (int a = 0; a < 8; a++) begin
            for (int f = 0; f < 64; f++) begin
                drive(1, a, f, 1, 0);
                acc = 1'b0;
                for (int k = 0; k < 20 && !acc; k++) step(acc);
                if (!acc) chk("sweep_accept_timeout", 0, 1);
                if (a == 0 && f == 42) chk("sweep_slt_sel", int'(bus.Sel), 7);
                if (a == 0 && f == 50) begin
                    chk("sweep_f50_sel", int'(bus.Sel), 15);
                    chk("sweep_f50_ill", int'(bus.illegal), 1);
                end
                if (a == 7 && f == 9) begin
                    chk("sweep_op7_sel", int'(bus.Sel), 15);
                    chk("sweep_op7_ill", int'(bus.illegal), 1);
                end
                if (a == 6 && f == 0) chk("sweep_beq_sel", int'(bus.Sel), 6);
            end
        end
        drive(0, 0, 0, 1, 0);
        repeat (M + 3) step(acc);

        // MULT then MFLO, with an ADD slipping through during RUN
        drive(1, 0, 24, 1, 0);
        step(acc);
        chk("mult_md_start", int'(bus.md_start), 1);
        chk("mult_md_busy",  int'(bus.md_busy),  1);
        drive(1, 0, 18, 1, 0);
        #1 chk("mflo_stall_t1", int'(bus.in_ready), 0);
        step(acc);
        drive(1, 0, 32, 1, 0);
        #1 chk("add_during_run", int'(bus.in_ready), 1);
        step(acc);
        chk("add_run_sel", int'(bus.Sel), 2);
        drive(1, 0, 18, 1, 0);
        #1 chk("mflo_stall_t3", int'(bus.in_ready), 0);
        step(acc);
        chk("mult_busy_t4", int'(bus.md_busy), 1);
        #1 chk("mflo_stall_t4", int'(bus.in_ready), 0);
        step(acc);
        chk("mult_done_t5", int'(bus.md_done), 1);
        #1 chk("mflo_accept_t5", int'(bus.in_ready), 1);
        step(acc);
        chk("mflo_sel_t6", int'(bus.Sel), 14);
        drive(0, 0, 0, 1, 0);
        step(acc);

        // Back-pressure with SUB held
        drive(1, 0, 34, 1, 0);
        step(acc);
        drive(1, 0, 36, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_sel_hold", int'(bus.Sel), 6);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            step(acc);
        end
        drive(1, 0, 36, 1, 0);
        #1 chk("bp_release_ready", int'(bus.in_ready), 1);
        step(acc);
        chk("bp_next_sel", int'(bus.Sel), 0);
        drive(0, 0, 0, 1, 0);
        step(acc);

        // DIVU followed by flush
        t0 = cyc;
        drive(1, 0, 27, 1, 0);
        step(acc);
        drive(1, 0, 32, 1, 1);
        #1 chk("flush_in_ready", int'(bus.in_ready), 0);
        step(acc);
        drive(0, 0, 0, 1, 0);
        chk("flush_out_valid", int'(bus.out_valid), 0);
        chk("flush_md_op", int'(bus.md_op), 3);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (bus.md_done) begin
                seen = 1'b1;
                chk("flush_done_cycle", cyc, t0 + M + 1);
            end else begin
                step(acc);
            end
        end
        if (!seen) chk("flush_done_timeout", 0, 1);
        step(acc);

        // Async reset in the middle of RUN
        drive(1, 0, 25, 1, 0);
        step(acc);
        drive(0, 0, 0, 1, 0);
        step(acc);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_sel",       int'(bus.Sel),       15);
        chk("arst_md_busy",   int'(bus.md_busy),   0);
        chk("arst_md_start",  int'(bus.md_start),  0);
        chk("arst_md_op",     int'(bus.md_op),     0);
        chk("arst_md_done",   int'(bus.md_done),   0);
        model_reset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        repeat (M + 4) step(acc);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int a, f;
            a = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(0, 7));
            f = ($urandom_range(0, 9) < 4) ? picks[$urandom_range(0, 5)]
                                           : int'($urandom_range(0, 63));
            drive(bit'($urandom_range(0, 3) != 0), a, f,
                  bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) == 0));
            step(acc);
        end
        drive(0, 0, 0, 1, 0);
        repeat (M + 3) step(acc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
